board_xform_ctrl: RTL and testbench

- Sequencer that applies the board-orientation transform to a block of consecutive 32-bit board words in shared data memory.
- Checkers bitboards are red pieces, black pieces and kings.
- The CPU writes the source and destination bases and pulses start. The block reads each word, transforms it, writes it to the destination, then pulses done.
- Sits between the CPU control registers and the data-memory arbiter. It is a memory requester using a req/gnt handshake.

---
 rtl/board_xform_ctrl.sv | 159 +++++++++++++++
 tb/tb_board_xform_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_xform_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_xform_ctrl
// Brief    : Reads NUM_WORDS board words, applies the per-byte low-nibble
//            bit reverse and writes them to a destination block over req/gnt.
//            Optional macro BOARD_XFORM_CHECKSUM_EN adds an XOR checksum output.
// Revision : 1.0
// ============================================================================
module board_xform_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int NUM_WORDS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef BOARD_XFORM_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] c_LAST_IDX = 8'(NUM_WORDS - 1);

    state_t            r_state;
    logic [7:0]        r_idx;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic              r_busy;
    logic              r_done;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
`ifdef BOARD_XFORM_CHECKSUM_EN
    logic [31:0]       r_checksum;
`endif

    logic [7:0]  w_idx_inc;
    logic [31:0] w_xform;

    assign w_idx_inc = r_idx + 8'd1;

    // Upper nibble of each byte passes through; lower nibble is bit-reversed.
    always_comb begin
        w_xform = '0;
        for (int k = 0; k < 4; k++) begin
            w_xform[8*k+4 +: 4] = mem_rdata[8*k+4 +: 4];
            for (int i = 0; i < 4; i++) begin
                w_xform[8*k+i] = mem_rdata[8*k+3-i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
`ifdef BOARD_XFORM_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_src      <= src_base;
                        r_dst      <= dst_base;
                        r_idx      <= '0;
                        r_addr     <= src_base;
                        r_req      <= 1'b1;
                        r_we       <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef BOARD_XFORM_CHECKSUM_EN
                        r_checksum <= '0;
`endif
                        r_state    <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    r_wdata <= w_xform;
                    r_addr  <= r_dst + ADDR_W'(r_idx);
                    r_req   <= 1'b1;
                    r_we    <= 1'b1;
                    r_state <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (mem_gnt) begin
`ifdef BOARD_XFORM_CHECKSUM_EN
                        r_checksum <= r_checksum ^ r_wdata;
`endif
                        r_we <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_addr  <= r_src + ADDR_W'(w_idx_inc);
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
`ifdef BOARD_XFORM_CHECKSUM_EN
    assign checksum  = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_xform_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_xform_ctrl
// Brief    : Self-checking bench: 3-word and 1-word instances share one memory
//            model; results are compared with a nibble-arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_board_xform_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [11:0] src_base;
    logic [11:0] dst_base;
    logic        mem_gnt;
    logic [31:0] mem_rdata;

    logic        start0, start1;
    logic        busy0, done0, req0, we0, busy1, done1, req1, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        m_busy, m_done, m_req, m_we;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
`ifdef BOARD_XFORM_CHECKSUM_EN
    logic [31:0] ck0, ck1, m_ck;
    assign m_ck = sel ? ck1 : ck0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:4095];
    logic [11:0] rd_log[$];
    logic [11:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    always #5 clock = ~clock;

    assign start0  = start & ~sel;
    assign start1  = start & sel;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_req   = sel ? req1   : req0;
    assign m_we    = sel ? we1    : we0;
    assign m_addr  = sel ? addr1  : addr0;
    assign m_wdata = sel ? wdata1 : wdata0;

    board_xform_ctrl #(.ADDR_W(12), .NUM_WORDS(3)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .src_base(src_base), .dst_base(dst_base),
        .busy(busy0), .done(done0), .mem_req(req0), .mem_we(we0),
        .mem_gnt(mem_gnt), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_rdata(mem_rdata)
`ifdef BOARD_XFORM_CHECKSUM_EN
        , .checksum(ck0)
`endif
    );

    board_xform_ctrl #(.ADDR_W(12), .NUM_WORDS(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .src_base(src_base), .dst_base(dst_base),
        .busy(busy1), .done(done1), .mem_req(req1), .mem_we(we1),
        .mem_gnt(mem_gnt), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_rdata(mem_rdata)
`ifdef BOARD_XFORM_CHECKSUM_EN
        , .checksum(ck1)
`endif
    );

    // Memory model: read data valid only in the cycle after an accepted read.
    always @(posedge clock) begin
        logic        hit;
        logic [31:0] rv;
        hit = 1'b0;
        rv  = $urandom;
        if (m_req && mem_gnt) begin
            if (m_we) begin
                mem[m_addr] = m_wdata;
                wr_addr_log.push_back(m_addr);
                wr_data_log.push_back(m_wdata);
            end else begin
                rd_log.push_back(m_addr);
                hit = 1'b1;
                rv  = mem[m_addr];
            end
        end
        #1 mem_rdata = rv;
    end

    function automatic logic [31:0] xf_ref(input logic [31:0] v);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            int b, lo, rev;
            b   = int'((v >> (8*k)) & 32'hFF);
            lo  = b & 15;
            rev = ((lo & 1) << 3) | ((lo & 2) << 1) | ((lo & 4) >> 1) | ((lo & 8) >> 3);
            r   = r | (32'((b & 'hF0) | rev) << (8*k));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // mode 0: gnt=1, mode 1: 5-cycle first-read / 3-cycle first-write stall,
    // mode 2: random gnt. poke pulses start with other bases mid-run.
    task automatic run_job(input logic [11:0] src, input logic [11:0] dst, input int nw,
                           input int mode, input bit poke, output int done_cyc);
        logic [11:0] e_ra[$];
        logic [11:0] e_wa[$];
        logic [31:0] e_wd[$];
        logic [31:0] shadow[int];
        logic [31:0] e_ck;
        logic        p_req, p_gnt, p_we;
        logic [11:0] p_addr;
        logic [31:0] p_wd;
        int          rd_left, wr_left;
        e_ck = 32'h0;
        for (int i = 0; i < nw; i++) begin
            int ra, wa;
            logic [31:0] v;
            ra = (int'(src) + i) % 4096;
            wa = (int'(dst) + i) % 4096;
            v  = shadow.exists(ra) ? shadow[ra] : mem[ra];
            e_ra.push_back(12'(ra));
            e_wa.push_back(12'(wa));
            e_wd.push_back(xf_ref(v));
            shadow[wa] = xf_ref(v);
            e_ck = e_ck ^ xf_ref(v);
        end
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        src_base = src;
        dst_base = dst;
        start    = 1'b1;
        mem_gnt  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        start    = 1'b0;
        src_base = 12'($urandom);
        dst_base = 12'($urandom);
        done_cyc = -1;
        rd_left  = 5;
        wr_left  = 3;
        p_req    = 1'b0;
        p_gnt    = 1'b0;
        p_we     = 1'b0;
        p_addr   = '0;
        p_wd     = '0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            n_checks++;
            if (m_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_during_run: cycle %0d got %b expected 1", cyc, m_busy);
            end
            if (p_req && !p_gnt) begin
                n_checks++;
                if ({m_req, m_we, m_addr} !== {1'b1, p_we, p_addr} || (p_we && m_wdata !== p_wd)) begin
                    n_fail++;
                    $display("FAIL req_hold: cycle %0d got req=%b we=%b addr=%h wd=%h expected req=1 we=%b addr=%h wd=%h",
                             cyc, m_req, m_we, m_addr, m_wdata, p_we, p_addr, p_wd);
                end
            end
            if (m_done === 1'b1) begin
                done_cyc = cyc;
`ifdef BOARD_XFORM_CHECKSUM_EN
                n_checks++;
                if (m_ck !== e_ck) begin
                    n_fail++;
                    $display("FAIL checksum: got %h expected %h", m_ck, e_ck);
                end
`endif
                break;
            end
            if (poke && cyc == 2) begin
                start    = 1'b1;
                src_base = 12'hABC;
                dst_base = 12'hABD;
            end else begin
                start = 1'b0;
            end
            if (mode == 1 && m_req && !m_we && rd_left > 0) begin
                mem_gnt = 1'b0;
                rd_left--;
            end else if (mode == 1 && m_req && m_we && wr_left > 0) begin
                mem_gnt = 1'b0;
                wr_left--;
            end else if (mode == 2) begin
                mem_gnt = ($urandom_range(0, 3) != 0);
            end else begin
                mem_gnt = 1'b1;
            end
            p_req  = m_req;
            p_gnt  = mem_gnt;
            p_we   = m_we;
            p_addr = m_addr;
            p_wd   = m_wdata;
            step();
        end
        start = 1'b0;
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
        step();
        n_checks++;
        if ({m_busy, m_done, m_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL after_done: got busy/done/req=%b expected 000", {m_busy, m_done, m_req});
        end
        n_checks++;
        if (rd_log.size() != nw || wr_addr_log.size() != nw) begin
            n_fail++;
            $display("FAIL access_count: got rd=%0d wr=%0d expected %0d each", rd_log.size(), wr_addr_log.size(), nw);
        end
        for (int i = 0; i < nw && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
            n_checks++;
            if (rd_log[i] !== e_ra[i] || wr_addr_log[i] !== e_wa[i] || wr_data_log[i] !== e_wd[i]) begin
                n_fail++;
                $display("FAIL word_%0d: got rd=%h wa=%h wd=%h expected rd=%h wa=%h wd=%h",
                         i, rd_log[i], wr_addr_log[i], wr_data_log[i], e_ra[i], e_wa[i], e_wd[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sel = 1'b0; mem_gnt = 1'b0;
        src_base = '0; dst_base = '0;
        step(); step();
        n_checks++;
        if ({busy0, done0, req0, we0, addr0, wdata0} !== '0 || {busy1, done1, req1, we1, addr1, wdata1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b expected all zero",
                     {busy0, done0, req0, we0, addr0, wdata0}, {busy1, done1, req1, we1, addr1, wdata1});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_word();
        int dc;
        sel = 1'b1;
        mem[12'h010] = 32'h12345678;
        run_job(12'h010, 12'h020, 1, 0, 1'b0, dc);
        n_checks++;
        if (dc != 4 || mem[12'h020] !== 32'h14325671) begin
            n_fail++;
            $display("FAIL single_word: got done_cyc=%0d mem=%h expected 4 14325671", dc, mem[12'h020]);
        end
        sel = 1'b0;
    endtask

    task automatic load3(input logic [11:0] src);
        mem[src]         = 32'h00000001;
        mem[12'(src+1)]  = 32'h0F0F0F0F;
        mem[12'(src+2)]  = 32'hFFFFFFFF;
    endtask

    task automatic test_three_word();
        int dc;
        load3(12'h040);
        run_job(12'h040, 12'h080, 3, 0, 1'b0, dc);
        n_checks++;
        if (dc != 10 || mem[12'h080] !== 32'h00000008 || mem[12'h081] !== 32'h0F0F0F0F || mem[12'h082] !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL three_word: got dc=%0d %h %h %h expected 10 00000008 0f0f0f0f ffffffff",
                     dc, mem[12'h080], mem[12'h081], mem[12'h082]);
        end
    endtask

    task automatic test_grant_stall();
        int dc;
        load3(12'h140);
        run_job(12'h140, 12'h180, 3, 1, 1'b0, dc);
        n_checks++;
        if (dc != 18) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 18", dc);
        end
    endtask

    task automatic test_wrap();
        int dc;
        run_job(12'hFFF, 12'hFFE, 3, 0, 1'b0, dc);
        n_checks++;
        if (rd_log.size() != 3 || wr_addr_log.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: got rd=%0d wr=%0d expected 3", rd_log.size(), wr_addr_log.size());
        end else if ({rd_log[0], rd_log[1], rd_log[2]} !== {12'hFFF, 12'h000, 12'h001} ||
                     {wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]} !== {12'hFFE, 12'hFFF, 12'h000}) begin
            n_fail++;
            $display("FAIL wrap_addr: got rd %h %h %h wr %h %h %h expected fff 000 001 / ffe fff 000",
                     rd_log[0], rd_log[1], rd_log[2], wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]);
        end
    endtask

    task automatic test_start_while_busy();
        int dc;
        run_job(12'h300, 12'h310, 3, 0, 1'b1, dc);
        n_checks++;
        if (dc != 10) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d expected 10", dc);
        end
    endtask

    task automatic test_reset_midrun();
        bit found;
        found = 1'b0;
        wr_addr_log.delete();
        src_base = 12'h500; dst_base = 12'h600;
        start = 1'b1; mem_gnt = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_req && m_we && wr_addr_log.size() == 1) begin
                found = 1'b1;
            end else begin
                step();
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrun_reach: got no second write request expected one");
        end
        mem_gnt = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_gnt = 1'b1;
        n_checks++;
        if ({busy0, done0, req0, we0, addr0, wdata0} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b expected all zero", {busy0, done0, req0, we0, addr0, wdata0});
        end
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (done0 !== 1'b0 || req0 !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_quiet: got done=%b req=%b expected 0 0", done0, req0);
            end
            step();
        end
        n_checks++;
        if (wr_addr_log.size() != 1) begin
            n_fail++;
            $display("FAIL midrun_writes: got %0d expected 1", wr_addr_log.size());
        end
    endtask

    task automatic test_start_with_reset();
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (busy0 !== 1'b0 || req0 !== 1'b0) begin
                n_fail++;
                $display("FAIL start_reset: got busy=%b req=%b expected 0 0", busy0, req0);
            end
            step();
        end
    endtask

    task automatic test_random();
        int dc;
        for (int t = 0; t < 10; t++) begin
            logic [11:0] s, d;
            s = 12'($urandom);
            d = (t == 3) ? s : 12'($urandom);
            sel = (t % 4 == 1);
            run_job(s, d, sel ? 1 : 3, 2, (t % 3 == 0), dc);
        end
        sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem_rdata = '0;
        test_reset();
        test_single_word();
        test_three_word();
        test_grant_stall();
        test_wrap();
        test_start_while_busy();
        test_reset_midrun();
        test_start_with_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
